// File: rtl/dma_fifo_drain.sv
// dma_fifo_drain
// Read-side consumer of the DMA data FIFO. Pops show-ahead FIFO words and
// presents them as an AXI4 write-data (W) beat stream through one registered
// output stage. wlast marks every MAX_BURST-th beat and the final beat of the
// transfer; the final beat carries the command's partial byte strobe.
//
// Optional feature macro: DMA_DRAIN_PERF_EN
//   defined   -> stall_empty_cnt_o / stall_bp_cnt_o are live saturating
//                32-bit stall counters, cleared on command accept.
//   undefined -> both counter ports are tied to zero (no counter flops).
//
// Ports:
//   clk, rstn               clock, synchronous active-low reset
//   clear_i                 synchronous abort of the current transfer
//   cmd_valid_i/cmd_ready_o command handshake (ready only while idle)
//   cmd_beats_i             total beats in the transfer (0 = empty transfer)
//   cmd_last_strb_i         byte strobe applied to the final beat
//   fifo_empty_i            FIFO empty flag
//   fifo_data_i             FIFO head word, valid while not empty
//   fifo_rd_o               pop the FIFO head this cycle
//   wvalid_o/wready_i       W channel handshake
//   wdata_o/wstrb_o/wlast_o W channel payload
//   busy_o                  transfer in progress (not idle)
//   done_o                  one-cycle pulse after the final beat is accepted
//   stall_empty_cnt_o       cycles the output stage starved on an empty FIFO
//   stall_bp_cnt_o          cycles a beat waited on wready_i
module dma_fifo_drain #(
  parameter int WIDTH     = 512,
  parameter int MAX_BURST = 16,
  parameter int BEAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [BEAT_W-1:0]    cmd_beats_i,
  input  logic [WIDTH/8-1:0]   cmd_last_strb_i,
  input  logic                 fifo_empty_i,
  input  logic [WIDTH-1:0]     fifo_data_i,
  output logic                 fifo_rd_o,
  output logic                 wvalid_o,
  input  logic                 wready_i,
  output logic [WIDTH-1:0]     wdata_o,
  output logic [WIDTH/8-1:0]   wstrb_o,
  output logic                 wlast_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          stall_empty_cnt_o,
  output logic [31:0]          stall_bp_cnt_o
);

  localparam int STRB_W = WIDTH / 8;
  localparam int POS_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(MAX_BURST - 1);
  localparam logic [BEAT_W-1:0] ONE_BEAT = BEAT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BEAT_W-1:0] pop_rem;
  logic [BEAT_W-1:0] acc_rem;
  logic [STRB_W-1:0] last_strb;
  logic [POS_W-1:0]  burst_pos;

  logic cmd_fire;
  logic load;
  logic pop;
  logic beat_acc;
  logic pop_is_last;
  logic pop_has_wlast;

  // The output stage can take a new word when it is empty or its beat is
  // leaving this cycle. Pops are suppressed during reset and abort so the
  // FIFO never loses a word the drain will not emit.
  assign load          = ~wvalid_o | wready_i;
  assign pop           = rstn & ~clear_i & (state == STREAM) & load &
                         ~fifo_empty_i & (pop_rem != '0);
  assign beat_acc      = wvalid_o & wready_i;
  assign cmd_fire      = cmd_valid_i & cmd_ready_o;
  assign pop_is_last   = (pop_rem == ONE_BEAT);
  assign pop_has_wlast = pop_is_last | (burst_pos == POS_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Acceptance of the final beat (acc_rem==1) ends streaming; pops are
  // already finished by then because every accepted beat was popped first.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_nxt = (cmd_beats_i == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (beat_acc && (acc_rem == ONE_BEAT)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (clear_i) begin
      state_nxt = IDLE;
    end
  end

  // cmd_ready_o also drops during an abort so a command is never handshaken
  // in a cycle where it would be discarded.
  always_comb begin
    cmd_ready_o = rstn & ~clear_i & (state == IDLE);
    busy_o      = (state != IDLE);
    done_o      = (state == DONE);
    fifo_rd_o   = pop;
  end

  // Output register and transfer bookkeeping. A held beat is only replaced
  // through pop, which requires load, so wdata/wstrb/wlast stay stable while
  // wvalid_o waits on wready_i.
  always_ff @(posedge clk) begin
    if (!rstn || clear_i) begin
      wvalid_o  <= 1'b0;
      wdata_o   <= '0;
      wstrb_o   <= '0;
      wlast_o   <= 1'b0;
      pop_rem   <= '0;
      acc_rem   <= '0;
      last_strb <= '0;
      burst_pos <= '0;
    end else begin
      if (cmd_fire) begin
        pop_rem   <= cmd_beats_i;
        acc_rem   <= cmd_beats_i;
        last_strb <= cmd_last_strb_i;
        burst_pos <= '0;
      end
      if (pop) begin
        wvalid_o  <= 1'b1;
        wdata_o   <= fifo_data_i;
        wstrb_o   <= pop_is_last ? last_strb : {STRB_W{1'b1}};
        wlast_o   <= pop_has_wlast;
        pop_rem   <= pop_rem - ONE_BEAT;
        burst_pos <= pop_has_wlast ? '0 : burst_pos + POS_W'(1);
      end else if ((state == STREAM) && load) begin
        wvalid_o <= 1'b0;
      end
      if (beat_acc) begin
        acc_rem <= acc_rem - ONE_BEAT;
      end
    end
  end

`ifdef DMA_DRAIN_PERF_EN
  logic [31:0] stall_empty_cnt;
  logic [31:0] stall_bp_cnt;
  logic        empty_stall;
  logic        bp_stall;

  assign empty_stall = (state == STREAM) & load & fifo_empty_i & (pop_rem != '0);
  assign bp_stall    = wvalid_o & ~wready_i;

  // Counters survive an abort for post-mortem reads; they restart with the
  // next command and saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_empty_cnt <= '0;
      stall_bp_cnt    <= '0;
    end else if (cmd_fire) begin
      stall_empty_cnt <= '0;
      stall_bp_cnt    <= '0;
    end else if (!clear_i) begin
      if (empty_stall && (stall_empty_cnt != '1)) begin
        stall_empty_cnt <= stall_empty_cnt + 32'd1;
      end
      if (bp_stall && (stall_bp_cnt != '1)) begin
        stall_bp_cnt <= stall_bp_cnt + 32'd1;
      end
    end
  end

  assign stall_empty_cnt_o = stall_empty_cnt;
  assign stall_bp_cnt_o    = stall_bp_cnt;
`else
  assign stall_empty_cnt_o = '0;
  assign stall_bp_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_dma_fifo_drain.sv
// tb_dma_fifo_drain
// Self-checking bench for dma_fifo_drain (WIDTH=128, MAX_BURST=4).
// A transaction-level scoreboard runs every cycle: it tracks the command in
// flight, the ordered list of words the bench pushed into its FIFO model and
// the expected beat index, and derives data/strobe/wlast/done/ready from the
// transfer rules. Directed tables and sequences cover the corner cases.
module tb_dma_fifo_drain;

  localparam int WIDTH     = 128;
  localparam int MAX_BURST = 4;
  localparam int BEAT_W    = 16;
  localparam int STRB_W    = WIDTH / 8;
`ifdef DMA_DRAIN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk;
  logic              rstn;
  logic              clear_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [BEAT_W-1:0] cmd_beats_i;
  logic [STRB_W-1:0] cmd_last_strb_i;
  logic              fifo_empty_i;
  logic [WIDTH-1:0]  fifo_data_i;
  logic              fifo_rd_o;
  logic              wvalid_o;
  logic              wready_i;
  logic [WIDTH-1:0]  wdata_o;
  logic [STRB_W-1:0] wstrb_o;
  logic              wlast_o;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       stall_empty_cnt_o;
  logic [31:0]       stall_bp_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] sb_q[$];

  bit               m_active;
  bit               m_done_due;
  int               m_beats;
  int               m_idx;
  int               m_pops;
  logic [STRB_W-1:0] m_strb;
  int unsigned      m_se;
  int unsigned      m_bp;

  typedef struct {
    bit cmd;
    bit wready;
    bit exp_rd;
    bit exp_wvalid;
    int exp_idx;
    bit exp_last;
    bit exp_done;
  } vec_t;

  vec_t vecs[0:18];

  dma_fifo_drain #(
    .WIDTH(WIDTH),
    .MAX_BURST(MAX_BURST),
    .BEAT_W(BEAT_W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .clear_i(clear_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_beats_i(cmd_beats_i),
    .cmd_last_strb_i(cmd_last_strb_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i(fifo_data_i),
    .fifo_rd_o(fifo_rd_o),
    .wvalid_o(wvalid_o),
    .wready_i(wready_i),
    .wdata_o(wdata_o),
    .wstrb_o(wstrb_o),
    .wlast_o(wlast_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .stall_empty_cnt_o(stall_empty_cnt_o),
    .stall_bp_cnt_o(stall_bp_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [WIDTH-1:0] make_word(int k);
    logic [31:0] kk;
    kk = k;
    return {32'hA5A5_0000 ^ kk, 32'h5A5A_0000 ^ kk, kk, ~kk};
  endfunction

  function automatic vec_t mk(bit cmd, bit wr, bit rd, bit wv, int idx, bit last, bit done);
    vec_t v;
    v.cmd = cmd; v.wready = wr; v.exp_rd = rd; v.exp_wvalid = wv;
    v.exp_idx = idx; v.exp_last = last; v.exp_done = done;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic settle();
    drive_fifo();
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
  endtask

  task automatic flush_queues();
    fifo_q.delete();
    sb_q.delete();
  endtask

  // One clock cycle: sample just before the edge, score it, advance the
  // transfer model at the edge, then retire popped FIFO words.
  task automatic apply_stimulus();
    logic s_rd, s_acc, s_cmd, exp_ready, exp_last;
    logic [WIDTH-1:0] w;
    drive_fifo();
    #2;
    exp_ready = rstn && !clear_i && !m_active && !m_done_due;
    check_output("cmd_ready", cmd_ready_o, exp_ready);
    if (rstn) begin
      check_output("done", done_o, m_done_due);
      check_output("busy", busy_o, m_active || m_done_due);
    end
    s_rd  = fifo_rd_o;
    s_acc = wvalid_o && wready_i;
    s_cmd = cmd_valid_i && exp_ready;
    if (rstn && !clear_i && m_active) begin
      if ((!wvalid_o || wready_i) && fifo_empty_i && (m_pops < m_beats)) m_se++;
      if (wvalid_o && !wready_i) m_bp++;
    end
    if (s_rd) begin
      check_output("rd_on_empty", fifo_empty_i, 0);
      check_output("pop_in_window", (m_active && (m_pops < m_beats)), 1);
      m_pops++;
    end
    if (s_acc && m_active) begin
      if (sb_q.size() == 0) begin
        check_output("beat_without_word", sb_q.size(), 1);
      end else begin
        w = sb_q.pop_front();
        exp_last = (m_idx == m_beats - 1) || ((m_idx % MAX_BURST) == MAX_BURST - 1);
        check_output("wdata", wdata_o, w);
        check_output("wstrb", wstrb_o, (m_idx == m_beats - 1) ? m_strb : {STRB_W{1'b1}});
        check_output("wlast", wlast_o, exp_last);
      end
      m_idx++;
    end
    @(posedge clk);
    if (!rstn || clear_i) begin
      m_active   = 1'b0;
      m_done_due = 1'b0;
      if (!rstn) begin
        m_se = 0;
        m_bp = 0;
      end
    end else begin
      if (m_done_due) m_done_due = 1'b0;
      if (s_acc && m_active && (m_idx == m_beats)) begin
        m_active   = 1'b0;
        m_done_due = 1'b1;
      end
      if (s_cmd) begin
        m_beats = cmd_beats_i;
        m_strb  = cmd_last_strb_i;
        m_idx   = 0;
        m_pops  = 0;
        m_se    = 0;
        m_bp    = 0;
        if (cmd_beats_i == 0) m_done_due = 1'b1;
        else m_active = 1'b1;
      end
    end
    #1;
    if (s_rd && (fifo_q.size() != 0)) w = fifo_q.pop_front();
    @(negedge clk);
  endtask

  task automatic send_cmd(input int beats, input logic [STRB_W-1:0] strb);
    cmd_valid_i     = 1'b1;
    cmd_beats_i     = beats[BEAT_W-1:0];
    cmd_last_strb_i = strb;
    apply_stimulus();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((m_active || m_done_due) && (n < limit)) begin
      apply_stimulus();
      n++;
    end
    check_output("idle_timeout", (m_active || m_done_due), 0);
  endtask

  task automatic check_perf();
    check_output("stall_empty_cnt", stall_empty_cnt_o, PERF ? m_se : 0);
    check_output("stall_bp_cnt", stall_bp_cnt_o, PERF ? m_bp : 0);
  endtask

  initial begin
    int rd_cnt;
    int pending;
    int n;
    int beats;

    // Transfer A: 5 beats, wready always high (words 0..4).
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 1, 1, 1, 1, 0, 0);
    vecs[4]  = mk(0, 1, 1, 1, 2, 0, 0);
    vecs[5]  = mk(0, 1, 1, 1, 3, 1, 0);
    vecs[6]  = mk(0, 1, 0, 1, 4, 1, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 0, 1);
    // Transfer B: same command, wready low 3 cycles on the third beat (words 5..9).
    vecs[8]  = mk(1, 1, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 1, 1, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 1, 1, 5, 0, 0);
    vecs[11] = mk(0, 1, 1, 1, 6, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 7, 0, 0);
    vecs[13] = mk(0, 0, 0, 1, 7, 0, 0);
    vecs[14] = mk(0, 0, 0, 1, 7, 0, 0);
    vecs[15] = mk(0, 1, 1, 1, 7, 0, 0);
    vecs[16] = mk(0, 1, 1, 1, 8, 1, 0);
    vecs[17] = mk(0, 1, 0, 1, 9, 1, 0);
    vecs[18] = mk(0, 1, 0, 0, 0, 0, 1);

    rstn = 1'b0; clear_i = 1'b0; cmd_valid_i = 1'b0; cmd_beats_i = '0;
    cmd_last_strb_i = '0; wready_i = 1'b1; fifo_empty_i = 1'b1; fifo_data_i = '0;
    m_active = 0; m_done_due = 0; m_beats = 0; m_idx = 0; m_pops = 0;
    m_strb = '0; m_se = 0; m_bp = 0;

    @(negedge clk);
    apply_stimulus();
    apply_stimulus();
    rstn = 1'b1;
    settle();
    $display("[TB] reset state");
    check_output("rst_wvalid", wvalid_o, 0);
    check_output("rst_wdata", wdata_o, 0);
    check_output("rst_wstrb", wstrb_o, 0);
    check_output("rst_wlast", wlast_o, 0);
    check_output("rst_done", done_o, 0);
    check_output("rst_rd", fifo_rd_o, 0);
    check_output("rst_ready", cmd_ready_o, 1);
    check_perf();

    $display("[TB] table: 5-beat transfers, free-running and back-pressured");
    for (int k = 0; k < 10; k++) push_word(make_word(k));
    rd_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      cmd_valid_i     = vecs[i].cmd;
      cmd_beats_i     = 16'd5;
      cmd_last_strb_i = 16'h00FF;
      wready_i        = vecs[i].wready;
      settle();
      check_output($sformatf("v%0d_rd", i), fifo_rd_o, vecs[i].exp_rd);
      check_output($sformatf("v%0d_wvalid", i), wvalid_o, vecs[i].exp_wvalid);
      check_output($sformatf("v%0d_done", i), done_o, vecs[i].exp_done);
      if (vecs[i].exp_wvalid) begin
        check_output($sformatf("v%0d_wdata", i), wdata_o, make_word(vecs[i].exp_idx));
        check_output($sformatf("v%0d_wlast", i), wlast_o, vecs[i].exp_last);
        check_output($sformatf("v%0d_wstrb", i), wstrb_o,
                     (vecs[i].exp_idx % 5 == 4) ? 16'h00FF : 16'hFFFF);
      end
      if (fifo_rd_o) rd_cnt++;
      apply_stimulus();
      if (i == 7) begin
        check_output("pops_A", rd_cnt, 5);
        rd_cnt = 0;
      end
    end
    cmd_valid_i = 1'b0;
    check_output("pops_B", rd_cnt, 5);
    check_output("bp_stall_3", stall_bp_cnt_o, PERF ? 3 : 0);
    check_perf();

    $display("[TB] empty FIFO gap between beats");
    wready_i = 1'b1;
    push_word(make_word(100));
    send_cmd(3, 16'h0003);
    apply_stimulus();
    apply_stimulus();
    settle();
    check_output("gap_wvalid_1", wvalid_o, 0);
    apply_stimulus();
    push_word(make_word(101));
    push_word(make_word(102));
    settle();
    check_output("gap_wvalid_2", wvalid_o, 0);
    check_output("gap_rd_resume", fifo_rd_o, 1);
    apply_stimulus();
    wait_idle(20);
    check_output("gap_pops", m_pops, 3);
    check_output("empty_stall_2", stall_empty_cnt_o, PERF ? 2 : 0);
    check_perf();

    $display("[TB] zero-beat command");
    fifo_q.push_back(make_word(200));
    send_cmd(0, 16'hFFFF);
    settle();
    check_output("zero_done", done_o, 1);
    check_output("zero_busy", busy_o, 1);
    check_output("zero_wvalid", wvalid_o, 0);
    check_output("zero_rd", fifo_rd_o, 0);
    apply_stimulus();
    settle();
    check_output("zero_busy_end", busy_o, 0);
    check_output("zero_rd_end", fifo_rd_o, 0);
    check_output("zero_wvalid_end", wvalid_o, 0);
    apply_stimulus();
    flush_queues();

    $display("[TB] abort after 10 accepted beats");
    for (int k = 0; k < 40; k++) push_word(make_word(300 + k));
    send_cmd(40, 16'h0001);
    wready_i = 1'b1;
    n = 0;
    while ((m_idx < 10) && (n < 100)) begin
      apply_stimulus();
      n++;
    end
    check_output("clr_reach_10", (m_idx >= 10), 1);
    clear_i = 1'b1;
    settle();
    check_output("clr_rd_forced", fifo_rd_o, 0);
    apply_stimulus();
    clear_i = 1'b0;
    flush_queues();
    settle();
    check_output("clr_wvalid", wvalid_o, 0);
    check_output("clr_ready", cmd_ready_o, 1);
    check_output("clr_busy", busy_o, 0);
    check_output("clr_done", done_o, 0);
    apply_stimulus();
    apply_stimulus();
    push_word(make_word(400));
    push_word(make_word(401));
    send_cmd(2, 16'h0F0F);
    wait_idle(50);
    check_output("post_clr_pops", m_pops, 2);
    check_perf();

    $display("[TB] reset mid-transfer");
    for (int k = 0; k < 8; k++) push_word(make_word(500 + k));
    send_cmd(8, 16'hFFFF);
    wready_i = 1'b1;
    apply_stimulus();
    wready_i = 1'b0;
    apply_stimulus();
    apply_stimulus();
    wready_i = 1'b1;
    apply_stimulus();
    rstn = 1'b0;
    apply_stimulus();
    rstn = 1'b1;
    flush_queues();
    settle();
    check_output("mrst_wvalid", wvalid_o, 0);
    check_output("mrst_wdata", wdata_o, 0);
    check_output("mrst_wstrb", wstrb_o, 0);
    check_output("mrst_wlast", wlast_o, 0);
    check_output("mrst_done", done_o, 0);
    check_output("mrst_busy", busy_o, 0);
    check_output("mrst_ready", cmd_ready_o, 1);
    check_output("mrst_stall_empty", stall_empty_cnt_o, 0);
    check_output("mrst_stall_bp", stall_bp_cnt_o, 0);
    apply_stimulus();

    $display("[TB] randomized transfers");
    for (int t = 0; t < 12; t++) begin
      beats = $urandom_range(1, 20);
      send_cmd(beats, 16'($urandom));
      pending = beats;
      n = 0;
      while ((m_active || m_done_due) && (n < 600)) begin
        if ((pending > 0) && (($urandom % 3) != 0)) begin
          push_word({$urandom, $urandom, $urandom, $urandom});
          pending--;
        end
        wready_i = (($urandom % 4) != 0);
        apply_stimulus();
        n++;
      end
      check_output("rand_timeout", (m_active || m_done_due), 0);
      check_output("rand_pops", m_pops, beats);
      check_perf();
      wready_i = 1'b1;
      flush_queues();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_fifo_drain.md
Name: dma_fifo_drain

Overview:
Read-side consumer of the DMA data FIFO. Pops FIFO words and emits them as an AXI4 write-data (W) beat stream: one registered output stage, wlast at burst boundaries, and a partial strobe on the final beat. It is driven by a per-transfer command from the DMA channel controller and sits between the FIFO read port and the AXI master W channel.

Parameters:
WIDTH, 512, data beat width in bits (multiple of 8)
MAX_BURST, 16, maximum beats per AXI burst (power of 2, >=1)
BEAT_W, 16, width of the transfer beat count

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
clear_i  input  1  synchronous abort of the current transfer
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command ready (high only in IDLE)
cmd_beats_i  input  BEAT_W  total beats in the transfer
cmd_last_strb_i  input  WIDTH/8  byte strobe for the final beat
fifo_empty_i  input  1  FIFO empty
fifo_data_i  input  WIDTH  FIFO head word (show-ahead; valid while ~fifo_empty_i)
fifo_rd_o  output  1  pop FIFO head this cycle
wvalid_o  output  1  W beat valid
wready_i  input  1  W beat ready
wdata_o  output  WIDTH  beat data
wstrb_o  output  WIDTH/8  beat strobe
wlast_o  output  1  last beat of the current burst
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle pulse when the final beat is accepted
stall_empty_cnt_o  output  32  perf counter (see Optional Feature)
stall_bp_cnt_o  output  32  perf counter (see Optional Feature)

Behaviour:
- Reset (rstn low at posedge): state=IDLE; wvalid_o, wdata_o, wstrb_o, wlast_o, done_o, fifo_rd_o = 0; all counters = 0. cmd_ready_o is 0 while rstn is low.
- States: IDLE, STREAM, DONE.
- IDLE: cmd_ready_o=1. On cmd_valid_i: latch pop_rem=cmd_beats_i, acc_rem=cmd_beats_i, last_strb, burst_pos=0. Go to STREAM, or to DONE when cmd_beats_i==0 (no beats emitted).
- STREAM:
  - load = ~wvalid_o | (wvalid_o & wready_i).
  - fifo_rd_o = load & ~fifo_empty_i & (pop_rem!=0). This is combinational, and fifo_rd_o is never high while fifo_empty_i is high.
  - On pop, at the next edge: wdata_o<=fifo_data_i; wvalid_o<=1; wstrb_o<=(pop_rem==1)?last_strb:all ones; wlast_o<=(pop_rem==1)|(burst_pos==MAX_BURST-1). Then pop_rem--; burst_pos increments, or wraps to 0 when the popped beat carries wlast.
  - If load and no pop: wvalid_o<=0.
  - Accepted beat (wvalid_o&wready_i): acc_rem--. When acc_rem==1 at acceptance, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. In STREAM, wvalid_o is deasserted in the same cycle done_o pulses.
- Latency: FIFO non-empty in cycle N -> wvalid_o in cycle N+1.
- Throughput: 1 beat/cycle sustained with wready_i=1 and the FIFO non-empty.
- AXI rule: once wvalid_o is high, wdata_o, wstrb_o and wlast_o are held stable until wready_i.
- Total pops per transfer equal cmd_beats_i exactly. No pop occurs once pop_rem==0.
- Bursts: ceil(beats/MAX_BURST) wlast pulses. The final burst may be short.
- clear_i (highest priority after reset): at the next edge, state=IDLE and wvalid_o=0. Counters are dropped and no done_o pulse occurs. fifo_rd_o is forced to 0 in the clear_i cycle. Flushing the FIFO itself is the owner's responsibility.
- Reset mid-transfer behaves identically to clear_i and also clears the perf counters.

Optional Feature:
DMA_DRAIN_PERF_EN
- Defined:
  - stall_empty_cnt_o increments each STREAM cycle with load & fifo_empty_i & pop_rem!=0.
  - stall_bp_cnt_o increments each cycle with wvalid_o & ~wready_i.
  - Both clear on command accept, saturate at 2^32-1, and hold after DONE.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Test Plan:
- MAX_BURST=4, cmd_beats=5, last_strb=64'hFF, FIFO preloaded D0..D4, wready=1 -> D0..D4 on 5 consecutive cycles; wlast on D3 and D4; wstrb all ones except D4=64'hFF; done_o one cycle after D4 accepted; exactly 5 fifo_rd_o pulses.
- Same command, wready low for 3 cycles while D2 is presented -> wdata=D2 held stable 4 cycles; no pop during the stall; stall_bp_cnt_o=3 with DMA_DRAIN_PERF_EN.
- cmd_beats=3, FIFO empty for 2 cycles between D0 and D1 -> wvalid_o low 2 cycles; order D0,D1,D2 preserved; stall_empty_cnt_o=2.
- cmd_beats=0 -> cmd accepted, done_o next cycle; wvalid_o and fifo_rd_o never asserted; busy_o high 1 cycle.
- cmd_beats=40, MAX_BURST=16, clear_i after 10 accepted beats -> wvalid_o=0 next cycle; IDLE, cmd_ready_o=1, no done_o; a subsequent cmd_beats=2 completes normally.
- rstn low mid-transfer for 1 cycle -> all outputs 0; IDLE; counters 0; cmd_ready_o=1 the cycle after rstn returns high.
